ps2_scancode_rx: RTL and testbench

//  Receives PS/2 keyboard frames on the raw ps2_clk/ps2_dat pins and turns them into scancode bytes.

---
 rtl/ps2_scancode_rx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver with make/break/extended scancode tracking
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] key,
  output logic       key_ext
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  state_t        r_state, w_state_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic          r_par_ok, w_par_ok_nxt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic          w_good, w_err, w_fall;
  logic [7:0]    r_byte_out, r_key;
  logic          r_byte_valid, r_frame_err, r_key_ext, r_ext_p, r_brk_p;

  assign w_fall     = r_clk_filt_d & ~r_clk_filt;
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign frame_err  = r_frame_err;
  assign key        = r_key;
  assign key_ext    = r_key_ext;

  // Two-flop synchronizers; idle bus level is high on both pins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN samples disagreeing with it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_ok  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par_ok  <= w_par_ok_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  // Frame FSM next state: bit capture on filtered falling edges, timeout while mid-frame
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_ok_nxt  = r_par_ok;
    w_to_cnt_nxt  = r_to_cnt;
    w_good        = 1'b0;
    w_err         = 1'b0;
    if (r_state == S_IDLE) begin
      w_to_cnt_nxt = '0;
      if (w_fall && !r_dat_s2) begin
        w_state_nxt   = S_DATA;
        w_bit_cnt_nxt = '0;
      end
    end else if (w_fall) begin
      w_to_cnt_nxt = '0;
      case (r_state)
        S_DATA: begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        end
        S_PARITY: begin
          w_par_ok_nxt = ^{r_shift, r_dat_s2};
          w_state_nxt  = S_STOP;
        end
        default: begin
          w_state_nxt = S_IDLE;
          if (r_dat_s2 && r_par_ok) w_good = 1'b1;
          else                      w_err  = 1'b1;
        end
      endcase
    end else if (r_to_cnt == TO_MAX) begin
      w_err         = 1'b1;
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_to_cnt_nxt  = '0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end
  end

  // Byte output stage: one-cycle pulses, byte held until the next good frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= w_good;
      r_frame_err  <= w_err;
      if (w_good) r_byte_out <= r_shift;
    end
  end

  // Scancode layer: prefixes E0/F0 qualify the next code; break only releases the held key
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key     <= '0;
      r_key_ext <= 1'b0;
      r_ext_p   <= 1'b0;
      r_brk_p   <= 1'b0;
    end else if (r_frame_err) begin
      r_ext_p <= 1'b0;
      r_brk_p <= 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte_out == 8'hE0) begin
        r_ext_p <= 1'b1;
      end else if (r_byte_out == 8'hF0) begin
        r_brk_p <= 1'b1;
      end else if (r_brk_p) begin
        if (r_byte_out == r_key) begin
          r_key     <= '0;
          r_key_ext <= 1'b0;
        end
        r_brk_p <= 1'b0;
        r_ext_p <= 1'b0;
      end else begin
        r_key     <= r_byte_out;
        r_key_ext <= r_ext_p;
        r_ext_p   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

  localparam int FLEN = 4;
  localparam int TOC  = 300;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] byte_out, key;
  logic       byte_valid, frame_err, key_ext;

  ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOC)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_err(frame_err),
    .key(key), .key_ext(key_ext)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic [7:0] k;
    logic       ke;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;
  int n_err_seen = 0;
  logic [7:0] m_key = 8'h00;
  logic m_ext = 1'b0, m_brk = 1'b0, m_extp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clock) cyc++;

  // Reference scancode behaviour, applied when a frame is queued
  task automatic push_good(input logic [7:0] b);
    exp_t e;
    if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      if (b == m_key) begin m_key = 8'h00; m_ext = 1'b0; end
      m_brk = 1'b0; m_extp = 1'b0;
    end else begin
      m_key = b; m_ext = m_extp; m_extp = 1'b0;
    end
    e.is_err = 1'b0; e.data = b; e.k = m_key; e.ke = m_ext;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    m_brk = 1'b0; m_extp = 1'b0;
    e.is_err = 1'b1; e.data = 8'h00; e.k = m_key; e.ke = m_ext;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_after);
    logic [10:0] bits;
    if (bad_par || bad_stop) push_err();
    else push_good(b);
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive_bit(bits[i]);
      if (i == glitch_after) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b1;
      end
    end
    ps2_dat = 1'b1;
    wait_cyc(3 * HALF);
  endtask

  // Monitor: pops the scoreboard on every pulse, checks key one cycle later
  logic       pend = 1'b0;
  logic [7:0] pend_k;
  logic       pend_ke;
  logic       prev_pulse = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      pend = 1'b0;
      prev_pulse = 1'b0;
    end else begin
      if (pend) begin
        check("key", key, pend_k);
        check("key_ext", key_ext, pend_ke);
        pend = 1'b0;
      end
      if (byte_valid || frame_err) begin
        check("bv_fe_exclusive", byte_valid & frame_err, 0);
        check("pulse_width", prev_pulse, 0);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pulse_kind_err", frame_err, e.is_err);
          if (byte_valid) check("byte_out", byte_out, e.data);
          pend = 1'b1; pend_k = e.k; pend_ke = e.ke;
        end
        if (frame_err) begin
          n_err_seen++;
          last_err_cyc = cyc;
        end
      end
      prev_pulse = byte_valid | frame_err;
    end
  end

  initial begin
    int start_errs, waited, lat;
    wait_cyc(5);
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_key", key, 0);
    check("rst_key_ext", key_ext, 0);
    reset = 1'b0;
    wait_cyc(10);

    send_frame(8'h1D, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1D, 0, 0, -1);

    send_frame(8'h1D, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1D, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h1C, 0, 0, -1);

    send_frame(8'h1B, 0, 0, -1);
    send_frame(8'h23, 1, 0, -1);
    send_frame(8'h23, 0, 1, -1);
    check("key_after_errs", key, 8'h1B);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    push_err();
    start_errs = n_err_seen;
    waited = 0;
    while (n_err_seen == start_errs && waited < 3 * TOC) begin
      @(posedge clock);
      waited++;
    end
    #1;
    check("timeout_fired", n_err_seen - start_errs, 1);
    lat = last_err_cyc - last_fall_cyc;
    check("timeout_latency", (lat >= TOC) && (lat <= TOC + FLEN + 8), 1);
    wait_cyc(10);
    send_frame(8'h23, 0, 0, -1);

    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);
    send_frame(8'hE0, 0, 0, -1);
    send_frame(8'hF0, 0, 0, -1);
    send_frame(8'h75, 0, 0, -1);

    send_frame(8'h1C, 0, 0, -1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset = 1'b1;
    #1;
    check("midrst_key", key, 0);
    check("midrst_byte_out", byte_out, 0);
    check("midrst_pulses", {byte_valid, frame_err}, 0);
    check("midrst_sb_empty", sb.size(), 0);
    m_key = 8'h00; m_ext = 1'b0; m_brk = 1'b0; m_extp = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(10);
    send_frame(8'h1B, 0, 0, -1);

    send_frame(8'h5A, 0, 0, 3);
    send_frame(8'h1C, 0, 0, 7);

    wait_cyc(50);
    check("sb_drained", sb.size(), 0);
    check("final_key", key, 8'h1C);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
